// File: rtl/stopwatch_lap_timer.sv
// Centisecond up/down stopwatch with refclk prescaler and lap buffer; `define LAP_DELTA_EN to store splits instead of absolute laps.
// Latency: time_out trails the counter by 1 cycle, lap_rd_data is 1 cycle after lap_rd_idx; pulse inputs only, no backpressure.
module stopwatch_lap_timer #(
    parameter int TICK_DIV  = 500000,
    parameter int TIME_W    = 19,
    parameter int MAX_TIME  = 359999,
    parameter int LAP_DEPTH = 8,
    parameter int LAP_AW    = 3
) (
    input  logic              refclk,
    input  logic              reset,
    input  logic              start_stop_p,
    input  logic              lap_p,
    input  logic              clear_p,
    input  logic              down_mode,
    input  logic [TIME_W-1:0] preset,
    output logic [TIME_W-1:0] time_out,
    output logic              running,
    output logic              frozen,
    output logic              tick,
    output logic              expired,
    output logic [LAP_AW:0]   lap_count,
    output logic              lap_full,
    input  logic [LAP_AW-1:0] lap_rd_idx,
    output logic [TIME_W-1:0] lap_rd_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]     PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TIME_W-1:0] MAX_T      = TIME_W'(MAX_TIME);
    localparam logic [LAP_AW:0]   LAP_MAX    = (LAP_AW + 1)'(LAP_DEPTH);

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [TIME_W-1:0]   cnt_q, cnt_d;
    logic [TIME_W-1:0]   cap_q, cap_d;
    logic [TIME_W-1:0]   time_out_q, time_out_d;
    logic [TIME_W-1:0]   rd_q, rd_d;
    logic                down_q, down_d;
    logic                frozen_q, frozen_d;
    logic [LAP_AW:0]     lap_count_q, lap_count_d;
    logic [TIME_W-1:0]   lap_mem_q [LAP_DEPTH];
    logic [TIME_W-1:0]   lap_mem_d [LAP_DEPTH];

    logic [TIME_W-1:0]   load_val;
    logic [TIME_W-1:0]   lap_split;
    logic                at_tick;
    logic                full;

`ifdef LAP_DELTA_EN
    localparam logic [TIME_W:0] MOD_T = (TIME_W + 1)'(MAX_TIME + 1);
    logic [TIME_W-1:0]   prev_q, prev_d;

    // Up-mode splits are taken modulo the wrap so a lap across 59:59.99 stays small.
    always_comb begin
        lap_split = '0;
        if (down_q)
            lap_split = prev_q - cnt_q;
        else if (cnt_q >= prev_q)
            lap_split = cnt_q - prev_q;
        else
            lap_split = TIME_W'({1'b0, cnt_q} + MOD_T - {1'b0, prev_q});
    end
`else
    always_comb begin
        lap_split = cnt_q;
    end
`endif

    assign load_val = down_mode ? ((preset > MAX_T) ? MAX_T : preset) : '0;
    assign at_tick  = (state_q == S_RUN) && (presc_q == PRESC_LAST);
    assign full     = (lap_count_q == LAP_MAX);

    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        down_d      = down_q;
        frozen_d    = frozen_q;
        lap_count_d = lap_count_q;
        lap_mem_d   = lap_mem_q;
`ifdef LAP_DELTA_EN
        prev_d      = prev_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d  = load_val;
                down_d = down_mode;
                if (clear_p) begin
                    lap_count_d = '0;
                    frozen_d    = 1'b0;
                end else if (start_stop_p) begin
                    presc_d = '0;
                    state_d = (down_mode && (load_val == '0)) ? S_DONE : S_RUN;
`ifdef LAP_DELTA_EN
                    prev_d  = load_val;
`endif
                end
            end
            S_RUN: begin
                // A lap captures the pre-tick count; clear_p is ignored here but still masks lap_p.
                if (start_stop_p) begin
                    state_d = S_PAUSE;
                end else if (lap_p && !clear_p) begin
                    frozen_d = 1'b1;
                    cap_d    = cnt_q;
                    if (!full) begin
                        lap_mem_d[lap_count_q[LAP_AW-1:0]] = lap_split;
                        lap_count_d = lap_count_q + 1'b1;
`ifdef LAP_DELTA_EN
                        prev_d = cnt_q;
`endif
                    end
                end
                presc_d = at_tick ? '0 : presc_q + 1'b1;
                if (at_tick) begin
                    if (!down_q) begin
                        cnt_d = (cnt_q == MAX_T) ? '0 : cnt_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == TIME_W'(1))
                            state_d = S_DONE;
                    end
                end
            end
            S_PAUSE: begin
                if (clear_p) begin
                    state_d     = S_IDLE;
                    lap_count_d = '0;
                    frozen_d    = 1'b0;
                end else if (start_stop_p) begin
                    state_d = S_RUN;
                end else if (lap_p) begin
                    frozen_d = 1'b0;
                end
            end
            default: begin
                cnt_d = '0;
                if (clear_p) begin
                    state_d     = S_IDLE;
                    lap_count_d = '0;
                    frozen_d    = 1'b0;
                end
            end
        endcase
    end

    always_comb begin
        time_out_d = frozen_q ? cap_q : cnt_q;
        rd_d       = '0;
        if ({1'b0, lap_rd_idx} < lap_count_q)
            rd_d = lap_mem_q[lap_rd_idx];
    end

    always_ff @(posedge refclk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            time_out_q  <= '0;
            rd_q        <= '0;
            down_q      <= 1'b0;
            frozen_q    <= 1'b0;
            lap_count_q <= '0;
            lap_mem_q   <= '{default: '0};
`ifdef LAP_DELTA_EN
            prev_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            time_out_q  <= time_out_d;
            rd_q        <= rd_d;
            down_q      <= down_d;
            frozen_q    <= frozen_d;
            lap_count_q <= lap_count_d;
            lap_mem_q   <= lap_mem_d;
`ifdef LAP_DELTA_EN
            prev_q      <= prev_d;
`endif
        end
    end

    assign time_out    = time_out_q;
    assign running     = (state_q == S_RUN);
    assign frozen      = frozen_q;
    assign tick        = at_tick;
    assign expired     = (state_q == S_DONE);
    assign lap_count   = lap_count_q;
    assign lap_full    = full;
    assign lap_rd_data = rd_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Directed scenarios plus random pulses, checked every cycle against a behavioural stopwatch model.
module tb_stopwatch_lap_timer;

    localparam int TD   = 4;
    localparam int TW   = 19;
    localparam int MAXT = 359999;
    localparam int LD   = 8;
    localparam int AW   = 3;

    logic          refclk = 1'b0;
    logic          reset  = 1'b0;
    logic          start_stop_p = 1'b0, lap_p = 1'b0, clear_p = 1'b0;
    logic          down_mode = 1'b0;
    logic [TW-1:0] preset = '0;
    logic [AW-1:0] lap_rd_idx = '0;
    logic [TW-1:0] time_out, lap_rd_data;
    logic          running, frozen, tick, expired, lap_full;
    logic [AW:0]   lap_count;

    stopwatch_lap_timer #(
        .TICK_DIV (TD), .TIME_W (TW), .MAX_TIME (MAXT), .LAP_DEPTH (LD), .LAP_AW (AW)
    ) dut (
        .refclk (refclk), .reset (reset),
        .start_stop_p (start_stop_p), .lap_p (lap_p), .clear_p (clear_p),
        .down_mode (down_mode), .preset (preset),
        .time_out (time_out), .running (running), .frozen (frozen), .tick (tick),
        .expired (expired), .lap_count (lap_count), .lap_full (lap_full),
        .lap_rd_idx (lap_rd_idx), .lap_rd_data (lap_rd_data)
    );

    always #5 refclk = ~refclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: mode 0=idle 1=run 2=pause 3=done, laps kept in a queue.
    int m_st, m_ph, m_tm, m_cap, m_disp, m_rd, m_prev;
    bit m_dn, m_frozen;
    int m_laps[$];

    task automatic model_reset();
        m_st = 0; m_ph = 0; m_tm = 0; m_cap = 0; m_disp = 0; m_rd = 0; m_prev = 0;
        m_dn = 0; m_frozen = 0;
        m_laps.delete();
    endtask

    task automatic model_edge(input bit ss, input bit lp, input bit clr);
        int load, old, n_disp, n_rd;
        n_disp = m_frozen ? m_cap : m_tm;
        n_rd   = (int'(lap_rd_idx) < m_laps.size()) ? m_laps[lap_rd_idx] : 0;
        case (m_st)
            0: begin
                load = down_mode ? ((int'(preset) > MAXT) ? MAXT : int'(preset)) : 0;
                m_tm = load;
                if (clr) begin
                    m_laps.delete(); m_frozen = 0;
                end else if (ss) begin
                    m_dn = down_mode; m_ph = 0; m_prev = load;
                    m_st = (down_mode && load == 0) ? 3 : 1;
                end
            end
            1: begin
                old = m_tm;
                if (ss) m_st = 2;
                else if (lp && !clr) begin
                    m_frozen = 1; m_cap = old;
                    if (m_laps.size() < LD) begin
`ifdef LAP_DELTA_EN
                        m_laps.push_back(m_dn ? (m_prev - old) : ((old - m_prev + MAXT + 1) % (MAXT + 1)));
`else
                        m_laps.push_back(old);
`endif
                        m_prev = old;
                    end
                end
                if (m_ph == TD - 1) begin
                    m_ph = 0;
                    if (!m_dn) m_tm = (old == MAXT) ? 0 : old + 1;
                    else begin
                        m_tm = old - 1;
                        if (m_tm == 0) m_st = 3;
                    end
                end else m_ph++;
            end
            2: begin
                if (clr) begin m_st = 0; m_laps.delete(); m_frozen = 0; end
                else if (ss) m_st = 1;
                else if (lp) m_frozen = 0;
            end
            default: begin
                m_tm = 0;
                if (clr) begin m_st = 0; m_laps.delete(); m_frozen = 0; end
            end
        endcase
        m_disp = n_disp;
        m_rd   = n_rd;
    endtask

    task automatic chk_all();
        chk("time_out", time_out, m_disp);
        chk("running", running, m_st == 1);
        chk("tick", tick, (m_st == 1) && (m_ph == TD - 1));
        chk("expired", expired, m_st == 3);
        chk("frozen", frozen, m_frozen);
        chk("lap_count", lap_count, m_laps.size());
        chk("lap_full", lap_full, m_laps.size() == LD);
        chk("lap_rd_data", lap_rd_data, m_rd);
    endtask

    // Called at a negedge; returns at the following negedge with outputs checked.
    task automatic step(input bit ss, input bit lp, input bit clr);
        start_stop_p = ss; lap_p = lp; clear_p = clr;
        @(posedge refclk);
        model_edge(ss, lp, clr);
        @(negedge refclk);
        start_stop_p = 0; lap_p = 0; clear_p = 0;
        chk_all();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt, k, e7;
        int tg[3];
        int lt[9];
        int exp_rd[4];
        bit l;
        tg = '{5, 12, 20};
`ifdef LAP_DELTA_EN
        exp_rd = '{5, 7, 8, 0};
`else
        exp_rd = '{5, 12, 20, 0};
`endif
        model_reset();

        #12;
        chk("rst_time_out", time_out, 0);
        chk("rst_flags", {running, frozen, tick, expired, lap_full}, 0);
        chk("rst_lap_count", lap_count, 0);
        chk("rst_rd", lap_rd_data, 0);
        @(negedge refclk);
        reset = 1'b1;

        // Up count: 40 cycles give 10 ticks, then pause holds the value.
        step(1, 0, 0);
        nt = 0;
        for (int c = 0; c < 40; c++) begin
            step(0, 0, 0);
            if (tick) nt++;
        end
        chk("tick_pulses", nt, 10);
        step(1, 0, 0);
        repeat (20) step(0, 0, 0);
        chk("pause_time_out", time_out, 10);
        chk("pause_running", running, 0);

        // Wrap from the top of the range.
        @(negedge refclk);
        force dut.cnt_q = 19'd359998;
        m_tm = 359998;
        step(0, 0, 0);
        release dut.cnt_q;
        step(1, 0, 0);
        nt = 0;
        for (int c = 0; c < 50 && nt < 2; c++) begin
            step(0, 0, 0);
            if (tick) nt++;
        end
        chk("wrap_ticks_seen", nt, 2);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("wrap_time_out", time_out, 0);
        chk("wrap_expired", expired, 0);

        // Countdown from 3 to expiry.
        step(1, 0, 0);
        step(0, 0, 1);
        down_mode = 1'b1; preset = 19'd3;
        step(0, 0, 0);
        step(0, 0, 0);
        chk("down_loaded", time_out, 3);
        step(1, 0, 0);
        for (int c = 0; c < 100 && !expired; c++) step(0, 0, 0);
        chk("down_expired", expired, 1);
        step(0, 0, 0);
        chk("down_time_out", time_out, 0);
        step(1, 0, 0);
        chk("done_ignores_start", running, 0);
        chk("done_still_expired", expired, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("clear_reload", time_out, 3);
        chk("clear_expired", expired, 0);

        // Laps at 5, 12, 20 and read-back.
        down_mode = 1'b0;
        step(0, 0, 0);
        step(1, 0, 0);
        k = 0;
        for (int c = 0; c < 400 && k < 3; c++) begin
            l = (m_tm == tg[k]);
            step(0, l, 0);
            if (l) begin lt[k] = tg[k]; k++; end
        end
        chk("lap_seq_done", k, 3);
        chk("lap_count3", lap_count, 3);
        chk("lap_frozen", frozen, 1);
        for (int i = 0; i < 4; i++) begin
            lap_rd_idx = AW'(i);
            step(0, 0, 0);
            chk($sformatf("lap_rd%0d", i), lap_rd_data, exp_rd[i]);
        end

        // Six more laps: buffer fills at 8, the ninth is dropped.
        for (int j = 3; j < 9; j++) begin
            repeat (3) step(0, 0, 0);
            lt[j] = m_tm;
            step(0, 1, 0);
        end
        chk("full_count", lap_count, 8);
        chk("full_flag", lap_full, 1);
`ifdef LAP_DELTA_EN
        e7 = lt[7] - lt[6];
`else
        e7 = lt[7];
`endif
        lap_rd_idx = 3'd7;
        step(0, 0, 0);
        chk("lap_rd7", lap_rd_data, e7);

        // Asynchronous reset in the middle of a run.
        step(1, 0, 0);
        step(0, 0, 1);
        step(1, 0, 0);
        for (int j = 0; j < 4; j++) begin
            repeat (3) step(0, 0, 0);
            step(0, 1, 0);
        end
        chk("pre_rst_frozen", frozen, 1);
        chk("pre_rst_laps", lap_count, 4);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_time_out", time_out, 0);
        chk("arst_flags", {running, frozen, tick, expired, lap_full}, 0);
        chk("arst_lap_count", lap_count, 0);
        chk("arst_rd", lap_rd_data, 0);
        model_reset();
        @(negedge refclk);
        reset = 1'b1;
        step(1, 0, 0);
        repeat (6) step(0, 0, 0);
        chk("resume_running", running, 1);
        chk("resume_time_out", time_out, 1);

        // Random pulses, modes and presets.
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                down_mode = 1'($urandom_range(0, 1));
                preset = ($urandom_range(0, 9) == 0) ? TW'(400000 + $urandom_range(0, 100000))
                                                     : TW'($urandom_range(0, 25));
            end
            lap_rd_idx = AW'($urandom_range(0, 7));
            step($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 19) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
